param_alu_datapath: RTL
=======================

Name: param_alu_datapath

Overview:
Parametrised successor to the single-cycle instruction datapath: a register file (one-hot C-bus write, binary-indexed A/B read), an ALU, a single-bit shifter, and registered N/Z/C flags. Adds a valid/ready operation handshake and an iterative multi-cycle multiply. Sits between the microsequencer (opcode/select source) and the memory interface (ext_in source).

Parameters:
WIDTH, 32, datapath and register width in bits
NUM_REGS, 9, number of registers; width of c_select
SEL_W, 4, width of a_select/b_select; indices >= NUM_REGS read as 0

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
op_valid  input  1  operation request
op_ready  output  1  high when a new operation can be accepted
alu_shifter_opcode  input  8  [7:6] shift ctrl, [5:0] ALU function
a_select  input  SEL_W  A-operand register index
b_select  input  SEL_W  B-operand register index
c_select  input  NUM_REGS  one-hot/multi-hot register write enables
ext_in  input  WIDTH  external load data
c_out  output  WIDTH  last result (post-shift)
n  output  1  result MSB
z  output  1  result == 0
c  output  1  carry/borrow from last add/sub/inc/dec
done  output  1  one-cycle pulse when a result is committed
illegal  output  1  one-cycle pulse on an undefined ALU code

Behaviour:
- Reset (reset==0 at posedge): all registers, c_out, n, z, c, done, illegal = 0; op_ready = 1; FSM -> IDLE. A reset during MUL aborts it with no register write.
- Accept on posedge with op_valid && op_ready. Operands A/B are captured at acceptance.
- ALU codes: 000000 A; 000001 B; 000010 A+B; 000011 A-B; 000100 A&B; 000101 A|B; 000110 A^B; 000111 ~B; 001000 B+1; 001001 B-1; 001010 0; 001011 all ones; 001100 ext_in; 010000 MUL. Any other code gives result 0, illegal=1, and a normal commit.
- Arithmetic is WIDTH-bit modulo. c = carry-out for add/inc and borrow (A<B) for sub/dec. c = 0 for all other codes.
- Shift (applied to the ALU result): 00 none; 01 logical left 1; 10 logical right 1; 11 arithmetic right 1.
- Single-cycle ops, in IDLE:
  - The commit happens on the acceptance edge: c_out <= shifted result; every register i with c_select[i]=1 <= shifted result; n/z/c update; done=1 for the next cycle.
  - op_ready stays 1, so back-to-back ops are accepted every cycle.
  - An op reading a register written by the previous op sees the new value.
- MUL: IDLE -> MUL on acceptance.
  - op_ready drops to 0 the next cycle.
  - Shift-add runs for WIDTH cycles, keeping the low WIDTH bits of A*B.
  - The commit edge is WIDTH cycles after acceptance. It applies the shift, c_select write, c_out/n/z, done pulse and c=0, then returns to IDLE with op_ready=1.
  - c_select, opcode and shift are latched at acceptance.
- op_valid while op_ready=0 is ignored; no queueing.
- c_select=0: no register write, but c_out, flags and done update. Multiple bits set: all selected registers are written.
- Outputs hold between commits. done and illegal are high only for the single cycle after a commit.

Test Plan:
- Reset held low 2 cycles with op_valid=1 -> c_out=0, n=z=c=0, op_ready=1, no writes; release, ext_in=5, op 00_001100, c_select=9'b000000001 -> R0=5, done pulse, z=0.
- R0=5, R1=7 via ext_in loads; op A+B (a=0,b=1), shift 01, c_select bit2 -> R2=24, c_out=24, n=0, c=0.
- R0=0, R1=1; A-B -> c_out=0xFFFFFFFF, n=1, c=1; then B-1 with b=1 -> c_out=0, z=1, c=0.
- R3=0x80000000, op B with shift 11 -> 0xC0000000, n=1; shift 10 -> 0x40000000, n=0.
- R0=1000, R1=3000, MUL -> op_ready low for 32 cycles, a second op_valid during this time is ignored; c_out=3000000 and done fire exactly 32 cycles after acceptance. Repeat with reset asserted at cycle 10 -> no write, op_ready=1.
- Opcode 00_111111 -> illegal pulse, c_out=0, z=1; back-to-back ALU ops on consecutive cycles each commit with a done pulse.

Source files
------------

// File: rtl/param_alu_datapath_if.sv
// Operation/result bundle between the microsequencer, memory interface and the ALU datapath.
interface param_alu_datapath_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 9,
  parameter int SEL_W    = 4
);
  logic                op_valid;
  logic                op_ready;
  logic [7:0]          alu_shifter_opcode;
  logic [SEL_W-1:0]    a_select;
  logic [SEL_W-1:0]    b_select;
  logic [NUM_REGS-1:0] c_select;
  logic [WIDTH-1:0]    ext_in;
  logic [WIDTH-1:0]    c_out;
  logic                n;
  logic                z;
  logic                c;
  logic                done;
  logic                illegal;

  modport master (
    output op_valid, alu_shifter_opcode, a_select, b_select, c_select, ext_in,
    input  op_ready, c_out, n, z, c, done, illegal
  );

  modport slave (
    input  op_valid, alu_shifter_opcode, a_select, b_select, c_select, ext_in,
    output op_ready, c_out, n, z, c, done, illegal
  );
endinterface

// File: rtl/param_alu_datapath.sv
// Register file + ALU + 1-bit shifter with N/Z/C flags; ALU ops commit on the accept edge, back-to-back.
// MUL is shift-add over WIDTH cycles, commits WIDTH cycles after accept; op_ready low meanwhile, no queueing.
module param_alu_datapath #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 9,
  parameter int SEL_W    = 4
) (
  input logic                 clock,
  input logic                 reset,
  param_alu_datapath_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] OP_A    = 6'h00;
  localparam logic [5:0] OP_B    = 6'h01;
  localparam logic [5:0] OP_ADD  = 6'h02;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h04;
  localparam logic [5:0] OP_OR   = 6'h05;
  localparam logic [5:0] OP_XOR  = 6'h06;
  localparam logic [5:0] OP_NOTB = 6'h07;
  localparam logic [5:0] OP_INC  = 6'h08;
  localparam logic [5:0] OP_DEC  = 6'h09;
  localparam logic [5:0] OP_ZERO = 6'h0A;
  localparam logic [5:0] OP_ONES = 6'h0B;
  localparam logic [5:0] OP_EXT  = 6'h0C;
  localparam logic [5:0] OP_MUL  = 6'h10;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t              state_q;
  logic                op_ready_q;
  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    c_out_q;
  logic                n_q, z_q, c_q, done_q, illegal_q;
  logic [WIDTH-1:0]    mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REGS-1:0] mul_csel_q;
  logic [1:0]          mul_shift_q;

  logic [5:0]          func;
  logic [1:0]          shift_ctl;
  logic [WIDTH-1:0]    opa_d, opb_d, alu_d, acc_sum_d;
  logic                carry_d, undef_d, mul_last;
  logic                commit_en, commit_c, commit_ill;
  logic [WIDTH-1:0]    commit_val;
  logic [NUM_REGS-1:0] commit_sel;

  function automatic logic [WIDTH-1:0] do_shift(input logic [1:0] ctl, input logic [WIDTH-1:0] v);
    case (ctl)
      2'b01:   return {v[WIDTH-2:0], 1'b0};
      2'b10:   return {1'b0, v[WIDTH-1:1]};
      2'b11:   return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  assign func      = bus.alu_shifter_opcode[5:0];
  assign shift_ctl = bus.alu_shifter_opcode[7:6];
  assign acc_sum_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last  = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));

  // Out-of-range select indices read as zero.
  always_comb begin
    opa_d = '0;
    opb_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(bus.a_select) == i) opa_d = regs_q[i];
      if (int'(bus.b_select) == i) opb_d = regs_q[i];
    end
  end

  always_comb begin
    alu_d   = '0;
    carry_d = 1'b0;
    undef_d = 1'b0;
    case (func)
      OP_A:    alu_d = opa_d;
      OP_B:    alu_d = opb_d;
      OP_ADD:  {carry_d, alu_d} = {1'b0, opa_d} + {1'b0, opb_d};
      OP_SUB:  begin alu_d = opa_d - opb_d; carry_d = (opa_d < opb_d); end
      OP_AND:  alu_d = opa_d & opb_d;
      OP_OR:   alu_d = opa_d | opb_d;
      OP_XOR:  alu_d = opa_d ^ opb_d;
      OP_NOTB: alu_d = ~opb_d;
      OP_INC:  {carry_d, alu_d} = {1'b0, opb_d} + (WIDTH + 1)'(1);
      OP_DEC:  begin alu_d = opb_d - WIDTH'(1); carry_d = (opb_d == '0); end
      OP_ZERO: alu_d = '0;
      OP_ONES: alu_d = '1;
      OP_EXT:  alu_d = bus.ext_in;
      OP_MUL:  alu_d = '0;
      default: undef_d = 1'b1;
    endcase
  end

  always_comb begin
    commit_en  = 1'b0;
    commit_val = '0;
    commit_sel = '0;
    commit_c   = 1'b0;
    commit_ill = 1'b0;
    if (state_q == S_MUL) begin
      commit_en  = mul_last;
      commit_val = do_shift(mul_shift_q, acc_sum_d);
      commit_sel = mul_csel_q;
    end else begin
      commit_en  = bus.op_valid && (func != OP_MUL);
      commit_val = do_shift(shift_ctl, alu_d);
      commit_sel = bus.c_select;
      commit_c   = carry_d;
      commit_ill = commit_en && undef_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_ready_q  <= 1'b1;
      c_out_q     <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_csel_q  <= '0;
      mul_shift_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      done_q    <= commit_en;
      illegal_q <= commit_ill;
      if (commit_en) begin
        c_out_q <= commit_val;
        n_q     <= commit_val[WIDTH-1];
        z_q     <= (commit_val == '0);
        c_q     <= commit_c;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (commit_sel[i]) regs_q[i] <= commit_val;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid && (func == OP_MUL)) begin
            state_q     <= S_MUL;
            op_ready_q  <= 1'b0;
            mcand_q     <= opa_d;
            mplier_q    <= opb_d;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_csel_q  <= bus.c_select;
            mul_shift_q <= shift_ctl;
          end
        end
        S_MUL: begin
          acc_q    <= acc_sum_d;
          mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            state_q    <= S_IDLE;
            op_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready = op_ready_q;
  assign bus.c_out    = c_out_q;
  assign bus.n        = n_q;
  assign bus.z        = z_q;
  assign bus.c        = c_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
endmodule
